// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon PIO output port with timed-pulse engine:
// register word addresses, STATUS bit positions and the pulse FSM encoding.
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA   = 3'd0;
  localparam logic [2:0] PIO_ADDR_SET    = 3'd1;
  localparam logic [2:0] PIO_ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] PIO_ADDR_PULSE  = 3'd3;
  localparam logic [2:0] PIO_ADDR_LEN    = 3'd4;
  localparam logic [2:0] PIO_ADDR_STATUS = 3'd5;
  localparam logic [2:0] PIO_ADDR_IRQ_EN = 3'd6;

  localparam int PIO_STATUS_BUSY = 0;
  localparam int PIO_STATUS_DONE = 1;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse length timer: loads max(len,1) on start, counts down while ACTIVE and
// flags the cycle on which the pulse ends (a retrigger never counts as an end).
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int PULSE_CW = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [PULSE_CW-1:0] i_len,
  output logic                o_busy,
  output logic                o_done_pulse
);

  pulse_state_e        r_state;
  pulse_state_e        w_nextState;
  logic [PULSE_CW-1:0] r_cnt;
  logic [PULSE_CW-1:0] w_nextCnt;
  logic [PULSE_CW-1:0] w_loadValue;

  assign w_loadValue = (i_len == '0) ? PULSE_CW'(1) : i_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PULSE_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // A start always wins, so a retrigger on the final cycle reloads instead of ending.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    o_done_pulse = 1'b0;
    if (i_start) begin
      w_nextState = PULSE_ACTIVE;
      w_nextCnt   = w_loadValue;
    end else if (r_state == PULSE_ACTIVE) begin
      if (r_cnt == PULSE_CW'(1)) begin
        w_nextState  = PULSE_IDLE;
        w_nextCnt    = '0;
        o_done_pulse = 1'b1;
      end else begin
        w_nextCnt = r_cnt - PULSE_CW'(1);
      end
    end
  end

  assign o_busy = (r_state == PULSE_ACTIVE);

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output port with atomic set/clear and a timed-pulse engine.
// Define PIO_PULSE_IRQ_EN to build the done flag, IRQ_EN register and irq output.
module avalon_pio_out_pulse
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    PULSE_CW    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [PULSE_CW-1:0]   r_len;
  logic                  w_write;
  logic                  w_wrPulse;
  logic                  w_busy;
  logic                  w_donePulse;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic                  w_unused;

  assign w_write   = chipselect & ~write_n;
  assign w_wrPulse = w_write && (address == PIO_ADDR_PULSE);
  assign w_wrData  = writedata[DATA_WIDTH-1:0];
  assign w_unused  = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
      r_len  <= '0;
    end else if (w_write) begin
      case (address)
        PIO_ADDR_DATA:  r_data <= w_wrData;
        PIO_ADDR_SET:   r_data <= r_data | w_wrData;
        PIO_ADDR_CLEAR: r_data <= r_data & ~w_wrData;
        PIO_ADDR_LEN:   r_len  <= writedata[PULSE_CW-1:0];
        default:        ;
      endcase
    end
  end

  // The mask is dropped as the pulse ends so an idle engine never leaks inversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wrPulse) begin
      r_mask <= w_wrData;
    end else if (w_donePulse) begin
      r_mask <= '0;
    end
  end

  pio_pulse_timer #(
    .PULSE_CW (PULSE_CW)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_wrPulse),
    .i_len        (r_len),
    .o_busy       (w_busy),
    .o_done_pulse (w_donePulse)
  );

  assign out_port = r_data ^ (w_busy ? r_mask : '0);

`ifdef PIO_PULSE_IRQ_EN
  logic r_done;
  logic r_irqEn;
  logic r_irq;
  logic w_doneNext;
  logic w_irqEnNext;

  // A pulse ending in the same cycle as a W1C keeps done set.
  always_comb begin
    w_doneNext  = r_done;
    w_irqEnNext = r_irqEn;
    if (w_write && (address == PIO_ADDR_STATUS) && writedata[PIO_STATUS_DONE]) begin
      w_doneNext = 1'b0;
    end
    if (w_donePulse) begin
      w_doneNext = 1'b1;
    end
    if (w_write && (address == PIO_ADDR_IRQ_EN)) begin
      w_irqEnNext = writedata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done  <= 1'b0;
      r_irqEn <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_done  <= w_doneNext;
      r_irqEn <= w_irqEnNext;
      r_irq   <= w_doneNext & w_irqEnNext;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:   readdata[DATA_WIDTH-1:0] = r_data;
      PIO_ADDR_LEN:    readdata[PULSE_CW-1:0]   = r_len;
      PIO_ADDR_STATUS: begin
        readdata[PIO_STATUS_BUSY] = w_busy;
`ifdef PIO_PULSE_IRQ_EN
        readdata[PIO_STATUS_DONE] = r_done;
`endif
      end
`ifdef PIO_PULSE_IRQ_EN
      PIO_ADDR_IRQ_EN: readdata[0] = r_irqEn;
`endif
      default:         readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Self-checking bench for avalon_pio_out_pulse: directed scenarios plus random
// bus traffic, all compared against a cycle-level behavioural model.
module tb_avalon_pio_out_pulse;

  localparam logic [7:0] RESET_VAL = 8'hA5;
`ifdef PIO_PULSE_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int assertCount = 0;
  int failCount = 0;

  // Behavioural model: pulse tracked as "cycles of inversion remaining".
  logic [7:0] mData;
  logic [7:0] mMask;
  int         mLen;
  int         mRemain;
  bit         mDone;
  bit         mIrqEn;

  avalon_pio_out_pulse #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (RESET_VAL),
    .PULSE_CW    (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, mData};
      3'd4:    return 32'(mLen);
      3'd5:    return {30'h0, mDone, (mRemain > 0)};
      3'd6:    return {31'h0, mIrqEn};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] modelOut();
    return mData ^ ((mRemain > 0) ? mMask : 8'h00);
  endfunction

  task automatic modelReset();
    mData = RESET_VAL; mMask = 8'h00; mLen = 0; mRemain = 0; mDone = 1'b0; mIrqEn = 1'b0;
  endtask

  task automatic modelStep(input logic [2:0] a, input bit wr, input logic [31:0] wd);
    bit ended = 1'b0;
    if (wr && a == 3'd3) begin
      mMask   = wd[7:0];
      mRemain = (mLen == 0) ? 1 : mLen;
    end else if (mRemain > 0) begin
      mRemain--;
      if (mRemain == 0) begin
        mMask = 8'h00;
        ended = 1'b1;
      end
    end
    if (wr) begin
      case (a)
        3'd0: mData = wd[7:0];
        3'd1: mData = mData | wd[7:0];
        3'd2: mData = mData & ~wd[7:0];
        3'd4: mLen  = int'(wd & 32'hFFFF);
        3'd5: if (IRQ_BUILD && wd[1]) mDone = 1'b0;
        3'd6: if (IRQ_BUILD) mIrqEn = wd[0];
        default: ;
      endcase
    end
    if (IRQ_BUILD && ended) mDone = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] a, input bit cs, input bit wrn, input logic [31:0] wd);
    @(negedge clk);
    address = a; chipselect = cs; write_n = wrn; writedata = wd;
    #1;
    checkOutput("readdata", readdata, modelRead(a));
    @(posedge clk);
    modelStep(a, cs && !wrn, wd);
    #1;
    checkOutput("out_port", {24'h0, out_port}, {24'h0, modelOut()});
    checkOutput("irq", {31'h0, irq}, {31'h0, mDone & mIrqEn});
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] wd);
    applyStimulus(a, 1'b1, 1'b0, wd);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(3'd5, 1'b0, 1'b1, 32'h0);
  endtask

  // Reset is asserted mid-cycle so the asynchronous path is what gets observed.
  task automatic applyReset();
    @(negedge clk);
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset out_port", {24'h0, out_port}, {24'h0, RESET_VAL});
    checkOutput("reset readdata", readdata, {24'h0, RESET_VAL});
    checkOutput("reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    int          r;

    modelReset();
    applyReset();

    $display("[TB] data/set/clear");
    writeReg(3'd0, 32'h0000_000F);
    writeReg(3'd1, 32'h0000_0030);
    writeReg(3'd2, 32'h0000_0005);
    applyStimulus(3'd0, 1'b1, 1'b1, 32'h0);
    checkOutput("data readback", {24'h0, out_port}, 32'h3A);

    $display("[TB] single pulse, LEN=3 then LEN=0");
    writeReg(3'd4, 32'd3);
    writeReg(3'd0, 32'h0);
    writeReg(3'd3, 32'h01);
    idleCycles(5);
    writeReg(3'd4, 32'd0);
    writeReg(3'd3, 32'h01);
    idleCycles(3);

    $display("[TB] retrigger");
    writeReg(3'd4, 32'd10);
    writeReg(3'd3, 32'h02);
    idleCycles(4);
    writeReg(3'd3, 32'h04);
    writeReg(3'd4, 32'd1);
    idleCycles(12);

    $display("[TB] reset mid-pulse");
    writeReg(3'd4, 32'd100);
    writeReg(3'd3, 32'hFF);
    idleCycles(19);
    applyReset();
    applyStimulus(3'd5, 1'b1, 1'b1, 32'h0);

    $display("[TB] done flag and irq");
    writeReg(3'd6, 32'h1);
    writeReg(3'd4, 32'd2);
    writeReg(3'd3, 32'h10);
    idleCycles(4);
    writeReg(3'd5, 32'h2);
    idleCycles(2);
    writeReg(3'd6, 32'h0);
    writeReg(3'd3, 32'h10);
    idleCycles(4);
    applyStimulus(3'd6, 1'b1, 1'b1, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 199);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd4) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 8));
      if (r == 0) applyReset();
      else if (r < 40) applyStimulus(a, 1'b0, 1'($urandom_range(0, 1)), d);
      else if (r < 90) applyStimulus(a, 1'b1, 1'b1, d);
      else applyStimulus(a, 1'b1, 1'b0, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
